// File: rtl/request_conditioner.sv
// request_conditioner
//   Conditions the raw pedestrian push-button and turn-lane loop detector
//   before they reach the intersection controller.
//   - Both raw inputs are brought into the clock domain through two-flop
//     synchronizers.
//   - The button is debounced, and its rising edge sets a sticky request.
//     The request is held until the pedestrian phase goes green.
//   - The turn loop must read high for TURN_PRESENCE_CYCLES consecutive
//     cycles before presence is reported.
//
// Ports
//   clock             in   single rising-edge clock
//   reset             in   synchronous, active-high reset
//   ped_button_raw    in   asynchronous, bouncing push-button contact
//   turn_loop_raw     in   asynchronous, noisy turn-lane loop detector
//   pedestrian_green  in   pedestrian phase active (clears the request)
//   pedestrian_button out  sticky pedestrian request
//   turn_sensor       out  qualified turn-lane presence
//   ped_wait_lamp     out  "wait" indicator, mirrors the request
module request_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 4,  // 1..255
  parameter int TURN_PRESENCE_CYCLES = 8   // 1..255
) (
  input  logic clock,
  input  logic reset,
  input  logic ped_button_raw,
  input  logic turn_loop_raw,
  input  logic pedestrian_green,
  output logic pedestrian_button,
  output logic turn_sensor,
  output logic ped_wait_lamp
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TURN_MAX = 8'(TURN_PRESENCE_CYCLES);

  // Synchronizers: index 0 = button, index 1 = turn loop.
  logic [1:0] w_raw;
  logic [1:0] w_sync;

  assign w_raw = {turn_loop_raw, ped_button_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic r_meta;
      logic r_sync;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_meta <= 1'b0;
          r_sync <= 1'b0;
        end else begin
          r_meta <= w_raw[gi];
          r_sync <= r_meta;
        end
      end

      assign w_sync[gi] = r_sync;
    end
  endgenerate

  logic w_s_btn;
  logic w_s_turn;

  assign w_s_btn  = w_sync[0];
  assign w_s_turn = w_sync[1];

  // Button debounce. The counter tracks how many consecutive cycles the
  // synchronized level has disagreed with the stable level. On the cycle it
  // would reach DEBOUNCE_CYCLES, the new level is accepted instead, so the
  // counter never exceeds DEBOUNCE_CYCLES-1.
  logic       r_stable;
  logic [7:0] r_deb_cnt;
  logic       w_differs;
  logic       w_accept;
  logic       w_press;

  assign w_differs = (w_s_btn != r_stable);
  assign w_accept  = w_differs && (r_deb_cnt == DEB_LAST);
  // Only an accepted 0->1 transition is a press; releases produce no event.
  assign w_press   = w_accept && w_s_btn;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stable  <= 1'b0;
      r_deb_cnt <= 8'd0;
    end else if (w_accept) begin
      r_stable  <= w_s_btn;
      r_deb_cnt <= 8'd0;
    end else if (w_differs) begin
      r_deb_cnt <= r_deb_cnt + 8'd1;
    end else begin
      r_deb_cnt <= 8'd0;
    end
  end

  // Request latch. The press is decoded combinationally, so the latch sets
  // on the same edge where the stable level rises. Green has priority, which
  // also discards a press that lands during the pedestrian phase.
  logic r_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req <= 1'b0;
    end else if (pedestrian_green) begin
      r_req <= 1'b0;
    end else if (w_press) begin
      r_req <= 1'b1;
    end
  end

  assign pedestrian_button = r_req;
  assign ped_wait_lamp     = r_req;

  // Turn presence. The counter saturates at TURN_MAX and clears on any
  // low sample, so a single dropout restarts qualification.
  logic [7:0] r_turn_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_turn_cnt <= 8'd0;
    end else if (!w_s_turn) begin
      r_turn_cnt <= 8'd0;
    end else if (r_turn_cnt != TURN_MAX) begin
      r_turn_cnt <= r_turn_cnt + 8'd1;
    end
  end

  assign turn_sensor = (r_turn_cnt == TURN_MAX);

endmodule

// File: tb/tb_request_conditioner.sv
// Directed testbench for request_conditioner with default parameters
// (DEBOUNCE_CYCLES = 4, TURN_PRESENCE_CYCLES = 8).
// Inputs change 1 time unit after a rising edge.
// "Edge i" counts rising edges after an input change, so the first edge that
// samples the new value is edge 1. Outputs are also sampled 1 time unit after
// each edge.
module tb_request_conditioner;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ped_button_raw = 1'b0;
  logic turn_loop_raw = 1'b0;
  logic pedestrian_green = 1'b0;
  logic pedestrian_button;
  logic turn_sensor;
  logic ped_wait_lamp;

  int total = 0;
  int bad = 0;

  request_conditioner dut (
    .clock            (clock),
    .reset            (reset),
    .ped_button_raw   (ped_button_raw),
    .turn_loop_raw    (turn_loop_raw),
    .pedestrian_green (pedestrian_green),
    .pedestrian_button(pedestrian_button),
    .turn_sensor      (turn_sensor),
    .ped_wait_lamp    (ped_wait_lamp)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ped_button_raw = 1'b1;
    turn_loop_raw = 1'b1;
    tick();
    tick();
    total++;
    if (pedestrian_button !== 1'b0) begin
      bad++;
      $display("FAIL reset_btn got=%b want=0", pedestrian_button);
    end
    total++;
    if (turn_sensor !== 1'b0) begin
      bad++;
      $display("FAIL reset_turn got=%b want=0", turn_sensor);
    end
    total++;
    if (ped_wait_lamp !== 1'b0) begin
      bad++;
      $display("FAIL reset_lamp got=%b want=0", ped_wait_lamp);
    end
    ped_button_raw = 1'b0;
    turn_loop_raw = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    $display("reset: outputs checked low");
  endtask

  // The request must rise on edge 6 of the press.
  // It must then stay high after the button is released.
  task automatic test_press();
    ped_button_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++;
      if (pedestrian_button !== (i >= 6)) begin
        bad++;
        $display("FAIL press_edge%0d btn got=%b want=%b", i, pedestrian_button, (i >= 6));
      end
      total++;
      if (ped_wait_lamp !== (i >= 6)) begin
        bad++;
        $display("FAIL press_edge%0d lamp got=%b want=%b", i, ped_wait_lamp, (i >= 6));
      end
    end
    ped_button_raw = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    total++;
    if (pedestrian_button !== 1'b1) begin
      bad++;
      $display("FAIL press_sticky got=%b want=1", pedestrian_button);
    end
    $display("press: request latched on edge 6 and held after release");
  endtask

  task automatic test_green_clear();
    pedestrian_green = 1'b1;
    tick();
    pedestrian_green = 1'b0;
    total++;
    if (pedestrian_button !== 1'b0) begin
      bad++;
      $display("FAIL green_clear got=%b want=0", pedestrian_button);
    end
    for (int i = 1; i <= 10; i++) tick();
    total++;
    if (pedestrian_button !== 1'b0 || ped_wait_lamp !== 1'b0) begin
      bad++;
      $display("FAIL green_no_reassert btn=%b lamp=%b want=0", pedestrian_button, ped_wait_lamp);
    end
    $display("green: request cleared, no re-assertion");
  endtask

  // The button pattern is 1,1,1,0, so it never has four consecutive highs.
  task automatic test_bounce();
    int errs;
    errs = 0;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        ped_button_raw = (k != 3);
        tick();
        if (pedestrian_button !== 1'b0) errs++;
      end
    end
    ped_button_raw = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (pedestrian_button !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bounce high_samples=%0d want=0", errs);
    end
    $display("bounce: 24 bouncing cycles, request stayed low");
  endtask

  // Green is asserted only for edge 6, which is when the press is accepted.
  task automatic test_press_during_green();
    ped_button_raw = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    pedestrian_green = 1'b1;
    tick();
    pedestrian_green = 1'b0;
    total++;
    if (pedestrian_button !== 1'b0) begin
      bad++;
      $display("FAIL green_press_edge6 got=%b want=0", pedestrian_button);
    end
    for (int i = 1; i <= 4; i++) tick();
    total++;
    if (pedestrian_button !== 1'b0) begin
      bad++;
      $display("FAIL green_press_after got=%b want=0", pedestrian_button);
    end
    ped_button_raw = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    $display("green_press: coincident press discarded");
  endtask

  // The loop reads high for 7 cycles, then low for 1, then high again.
  // Presence must appear on edge 10 of the second burst.
  // It must drop 3 edges after the loop goes low.
  task automatic test_turn();
    int errs;
    errs = 0;
    turn_loop_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (turn_sensor !== 1'b0) errs++;
    end
    turn_loop_raw = 1'b0;
    tick();
    if (turn_sensor !== 1'b0) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL turn_short_burst high_samples=%0d want=0", errs);
    end
    turn_loop_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      total++;
      if (turn_sensor !== (i >= 10)) begin
        bad++;
        $display("FAIL turn_rise_edge%0d got=%b want=%b", i, turn_sensor, (i >= 10));
      end
    end
    turn_loop_raw = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (turn_sensor !== (i < 3)) begin
        bad++;
        $display("FAIL turn_fall_edge%0d got=%b want=%b", i, turn_sensor, (i < 3));
      end
    end
    $display("turn: short burst rejected, rise at edge 10, fall at edge 3");
  endtask

  // A second press while the request is already latched must not disturb it.
  task automatic test_back_to_back();
    ped_button_raw = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    ped_button_raw = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    ped_button_raw = 1'b1;
    for (int i = 1; i <= 8; i++) tick();
    total++;
    if (pedestrian_button !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back got=%b want=1", pedestrian_button);
    end
    ped_button_raw = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    $display("back_to_back: second press left request set");
  endtask

  // Reset arrives while a request is latched and a new press is
  // mid-debounce. The button is then held through reset release.
  task automatic test_reset_mid();
    turn_loop_raw = 1'b1;
    ped_button_raw = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    total++;
    if (pedestrian_button !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got=%b want=1", pedestrian_button);
    end
    reset = 1'b1;
    tick();
    total++;
    if (pedestrian_button !== 1'b0 || ped_wait_lamp !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_req btn=%b lamp=%b want=0", pedestrian_button, ped_wait_lamp);
    end
    total++;
    if (turn_sensor !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_turn got=%b want=0", turn_sensor);
    end
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++;
      if (pedestrian_button !== (i >= 6)) begin
        bad++;
        $display("FAIL rstmid_requal_edge%0d got=%b want=%b", i, pedestrian_button, (i >= 6));
      end
    end
    ped_button_raw = 1'b0;
    turn_loop_raw = 1'b0;
    $display("reset_mid: progress discarded, held button re-qualified on edge 6");
  endtask

  initial begin
    test_reset();
    test_press();
    test_green_clear();
    test_bounce();
    test_press_during_green();
    test_turn();
    test_back_to_back();
    // This leaves a request latched for the reset test that follows.
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
